// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Increment with wrap at n; n need not be a power of two.
    function automatic int wrap_inc(input int p, input int n);
        return (p + 1 >= n) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/fifo_write_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter; slave = arbiter, master = environment.
interface fifo_write_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            grant;
    logic                          mem_full;
    logic                          write_en;
    logic [DATA_WIDTH-1:0]         data_in;
    logic [IDX_W-1:0]              grant_id;

    modport slave (
        input  req, req_data, mem_full,
        output grant, write_en, data_in, grant_id
    );

    modport master (
        output req, req_data, mem_full,
        input  grant, write_en, data_in, grant_id
    );

endinterface

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above rr_ptr, with wrap.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int             j;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            cand = IDX_W'(j);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter feeding the async FIFO write port from NUM_REQ requesters.
// Optional burst mode: define FIFO_WRITE_ARB_BURST_EN.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BURST_LEN  = 4
) (
    input  logic                 write_clk,
    input  logic                 reset,
    fifo_write_arbiter_if.slave  arb_if
);
    localparam int IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1) begin : g_param_check
        $error("fifo_write_arbiter: NUM_REQ must be 2..8 and BURST_LEN >= 1");
    end

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
        return IDX_W'(wrap_inc(int'(p), NUM_REQ));
    endfunction

    logic                  write_en_q, write_en_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0]      grant_id_q, grant_id_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;

    logic                  can_accept;
    logic [NUM_REQ-1:0]    req_mask;
    logic [NUM_REQ-1:0]    req_eff;
    logic [NUM_REQ-1:0]    pick_grant;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_any;

    // A held word blocks new grants only while the FIFO refuses it.
    assign can_accept = !write_en_q || !arb_if.mem_full;
    assign req_eff    = can_accept ? (arb_if.req & req_mask) : '0;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (req_eff),
        .rr_ptr (rr_ptr_q),
        .grant  (pick_grant),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign arb_if.grant    = pick_grant;
    assign arb_if.write_en = write_en_q;
    assign arb_if.data_in  = data_q;
    assign arb_if.grant_id = grant_id_q;

    always_comb begin
        write_en_d = write_en_q;
        data_d     = data_q;
        grant_id_d = grant_id_q;
        if (can_accept) begin
            if (pick_any) begin
                write_en_d = 1'b1;
                data_d     = arb_if.req_data[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                grant_id_d = pick_idx;
            end else begin
                write_en_d = 1'b0;
            end
        end
    end

    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            write_en_q <= 1'b0;
            data_q     <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            write_en_q <= write_en_d;
            data_q     <= data_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

`ifdef FIFO_WRITE_ARB_BURST_EN
    // state | meaning
    // IDLE  | round-robin over all requesters from rr_ptr
    // BURST | only owner_q may be granted, up to BURST_LEN words
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    burst_state_t      state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [IDX_W-1:0]  owner_q, owner_d;

    always_comb begin
        req_mask = '1;
        if (state_q == BURST) begin
            req_mask          = '0;
            req_mask[owner_q] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    if (BURST_LEN <= 1) begin
                        rr_ptr_d = next_ptr(pick_idx);
                    end else begin
                        state_d = BURST;
                        count_d = CNT_W'(1);
                    end
                end
            end
            BURST: begin
                // Owner dropping req in an accept cycle ends the burst with no grant.
                if (can_accept) begin
                    if (pick_any && (int'(count_q) + 1 < BURST_LEN)) begin
                        count_d = count_q + CNT_W'(1);
                    end else begin
                        state_d  = IDLE;
                        count_d  = '0;
                        rr_ptr_d = next_ptr(owner_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge write_clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            owner_q <= owner_d;
        end
    end
`else
    assign req_mask = '1;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (pick_any) begin
            rr_ptr_d = next_ptr(pick_idx);
        end
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: rule-level model checked every cycle plus directed literal checks.
module tb_fifo_write_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;

    logic write_clk = 1'b0;
    logic reset     = 1'b0;

    fifo_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) bus ();

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .write_clk (write_clk),
        .reset     (reset),
        .arb_if    (bus)
    );

    always #5 write_clk = ~write_clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model state: the word held for the FIFO, the round-robin pointer, burst ownership.
    int m_valid = 0, m_data = 0, m_id = 0, m_ptr = 0;
    int m_burst = 0, m_owner = 0, m_cnt = 0;
    int nx_valid, nx_data, nx_id, nx_ptr, nx_burst, nx_owner, nx_cnt;
    int nx_wrote, nx_wdata;
    bit nx_ok = 1'b0;
    int e_can, e_g, e_j;
    logic [7:0] wlog[$];
    logic [7:0] exp_q[$];

    always @(negedge write_clk) begin
        if (!reset) begin
            e_can = (m_valid == 0 || !bus.mem_full) ? 1 : 0;
            e_g   = -1;
            if (e_can != 0) begin
                if (m_burst != 0) begin
                    if (bus.req[m_owner]) e_g = m_owner;
                end else begin
                    for (int k = 0; k < N; k++) begin
                        e_j = (m_ptr + k) % N;
                        if (e_g < 0 && bus.req[e_j]) e_g = e_j;
                    end
                end
            end
            check("grant", 32'(bus.grant), (e_g < 0) ? 32'd0 : (32'd1 << e_g));
            check("write_en", 32'(bus.write_en), 32'(m_valid));
            check("data_in", 32'(bus.data_in), 32'(m_data));
            check("grant_id", 32'(bus.grant_id), 32'(m_id));

            nx_wrote = (m_valid != 0 && !bus.mem_full) ? 1 : 0;
            nx_wdata = m_data;
            nx_valid = m_valid; nx_data = m_data; nx_id = m_id; nx_ptr = m_ptr;
            nx_burst = m_burst; nx_owner = m_owner; nx_cnt = m_cnt;
            if (e_can != 0) begin
                if (e_g >= 0) begin
                    nx_valid = 1;
                    nx_data  = int'(bus.req_data[e_g*DW +: DW]);
                    nx_id    = e_g;
                end else begin
                    nx_valid = 0;
                end
            end
`ifdef FIFO_WRITE_ARB_BURST_EN
            if (m_burst == 0) begin
                if (e_g >= 0) begin
                    if (BL <= 1) nx_ptr = (e_g + 1) % N;
                    else begin nx_burst = 1; nx_owner = e_g; nx_cnt = 1; end
                end
            end else if (e_can != 0) begin
                if (e_g >= 0) nx_cnt = m_cnt + 1;
                if (e_g < 0 || nx_cnt >= BL) begin
                    nx_burst = 0;
                    nx_ptr   = (m_owner + 1) % N;
                end
            end
`else
            if (e_g >= 0) nx_ptr = (e_g + 1) % N;
`endif
            nx_ok = 1'b1;
        end
    end

    always @(posedge write_clk or posedge reset) begin
        if (reset) begin
            m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0;
            m_burst = 0; m_owner = 0; m_cnt = 0;
            nx_ok = 1'b0;
        end else if (nx_ok) begin
            if (nx_wrote != 0) wlog.push_back(8'(nx_wdata));
            m_valid = nx_valid; m_data = nx_data; m_id = nx_id; m_ptr = nx_ptr;
            m_burst = nx_burst; m_owner = nx_owner; m_cnt = nx_cnt;
            nx_ok = 1'b0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge write_clk);
        #1;
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, 32'(wlog.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check(name, (i < wlog.size()) ? 32'(wlog[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req      = '0;
        bus.mem_full = 1'b0;
        bus.req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        #1 reset = 1'b1;
        #2;
        check("rst_write_en", 32'(bus.write_en), 32'd0);
        check("rst_data_in", 32'(bus.data_in), 32'd0);
        check("rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        @(posedge write_clk);
        #1 reset = 1'b0;
        cyc(1);

`ifndef FIFO_WRITE_ARB_BURST_EN
        // Round-robin with all requesters active
        wlog.delete();
        bus.req = 4'hF;
        cyc(5);
        bus.req = '0;
        cyc(2);
        exp_q = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10};
        check_log("rr_seq");

        // Full stall on 0x21 while requester 2 waits
        wlog.delete();
        bus.req = 4'b0010;
        cyc(1);
        bus.req      = 4'b0100;
        bus.mem_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge write_clk);
            check("stall_write_en", 32'(bus.write_en), 32'd1);
            check("stall_data_in", 32'(bus.data_in), 32'h21);
            check("stall_grant", 32'(bus.grant), 32'd0);
            cyc(1);
        end
        bus.mem_full = 1'b0;
        @(negedge write_clk);
        check("unstall_grant", 32'(bus.grant), 32'b0100);
        cyc(1);
        bus.req = '0;
        cyc(2);
        exp_q = '{8'h21, 8'h32};
        check_log("stall_seq");

        // Sparse request and pointer wrap
        bus.req = 4'b0001;
        cyc(1);
        bus.req = 4'b1000;
        @(negedge write_clk);
        check("sparse_grant3", 32'(bus.grant), 32'b1000);
        cyc(1);
        bus.req = 4'b1001;
        @(negedge write_clk);
        check("wrap_grant0", 32'(bus.grant), 32'b0001);
        cyc(1);
        bus.req = '0;
        cyc(2);

        // Withdrawn request during a stall
        wlog.delete();
        bus.req = 4'b0100;
        cyc(1);
        bus.req      = 4'b0010;
        bus.mem_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge write_clk);
            check("withdraw_grant", 32'(bus.grant), 32'd0);
            cyc(1);
        end
        bus.req = '0;
        @(negedge write_clk);
        check("withdraw_grant", 32'(bus.grant), 32'd0);
        cyc(1);
        bus.mem_full = 1'b0;
        @(negedge write_clk);
        check("withdraw_grant", 32'(bus.grant), 32'd0);
        cyc(2);
        exp_q = '{8'h32};
        check_log("withdraw_seq");
`else
        // Burst: requesters 0 and 2 each get BL consecutive words
        wlog.delete();
        bus.req = 4'b0101;
        cyc(8);
        bus.req = '0;
        cyc(2);
        exp_q = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h32, 8'h32, 8'h32, 8'h32};
        check_log("burst_seq");

        // Owner drops after two words; grant moves to 2 in the next accept cycle
        wlog.delete();
        bus.req = 4'b0101;
        cyc(2);
        bus.req = 4'b0100;
        @(negedge write_clk);
        check("owner_drop_gap", 32'(bus.grant), 32'd0);
        cyc(1);
        @(negedge write_clk);
        check("pass_to_2", 32'(bus.grant), 32'b0100);
        cyc(1);
        bus.req = '0;
        cyc(2);
        exp_q = '{8'h10, 8'h10, 8'h32};
        check_log("drop_seq");
`endif

        // Reset in the middle of a stall discards the held word
        wlog.delete();
        bus.req = 4'b1000;
        cyc(1);
        bus.req      = '0;
        bus.mem_full = 1'b1;
        @(negedge write_clk);
        check("pre_rst_write_en", 32'(bus.write_en), 32'd1);
        check("pre_rst_grant_id", 32'(bus.grant_id), 32'd3);
        reset = 1'b1;
        #1;
        check("mid_rst_write_en", 32'(bus.write_en), 32'd0);
        check("mid_rst_grant_id", 32'(bus.grant_id), 32'd0);
        check("mid_rst_data_in", 32'(bus.data_in), 32'd0);
        cyc(2);
        reset        = 1'b0;
        bus.mem_full = 1'b0;
        cyc(3);
        exp_q = {};
        check_log("post_rst_seq");
        check("post_rst_write_en", 32'(bus.write_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
